dram_port_arbiter: RTL and testbench

- Shares the single external DRAM request interface between two requesters: client 0 (DMA controller) and client 1 (a future cache-refill or video fetch unit).
- Sits between those requesters and the top-level dram_* pins of the core.
- Arbitrates with round-robin or fixed priority and latches one transaction at a time.
- Routes each completion pulse back to the client that owns the transaction.

---
 rtl/dram_port_arbiter_if.sv | 48 ++++
 rtl/dram_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_dram_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_port_arbiter_if.sv
// Bundle of the two client request ports and the external DRAM request port.
// slave is the arbiter's view; master is the surrounding clients plus DRAM.
interface dram_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] c0_addr;
    logic [DATA_W-1:0] c0_wdata;
    logic              c0_req_read;
    logic              c0_req_write;
    logic [DATA_W-1:0] c0_rdata;
    logic              c0_data_valid;
    logic              c0_write_complete;

    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c1_wdata;
    logic              c1_req_read;
    logic              c1_req_write;
    logic [DATA_W-1:0] c1_rdata;
    logic              c1_data_valid;
    logic              c1_write_complete;

    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_data_out;
    logic              dram_req_read;
    logic              dram_req_write;
    logic [DATA_W-1:0] dram_data_in;
    logic              dram_data_valid;
    logic              dram_write_complete;

    modport slave (
        input  c0_addr, c0_wdata, c0_req_read, c0_req_write,
        output c0_rdata, c0_data_valid, c0_write_complete,
        input  c1_addr, c1_wdata, c1_req_read, c1_req_write,
        output c1_rdata, c1_data_valid, c1_write_complete,
        output dram_addr, dram_data_out, dram_req_read, dram_req_write,
        input  dram_data_in, dram_data_valid, dram_write_complete
    );

    modport master (
        output c0_addr, c0_wdata, c0_req_read, c0_req_write,
        input  c0_rdata, c0_data_valid, c0_write_complete,
        output c1_addr, c1_wdata, c1_req_read, c1_req_write,
        input  c1_rdata, c1_data_valid, c1_write_complete,
        input  dram_addr, dram_data_out, dram_req_read, dram_req_write,
        output dram_data_in, dram_data_valid, dram_write_complete
    );
endinterface

// File: rtl/dram_port_arbiter.sv
// Two-client arbiter for the single DRAM request port: grants one transaction
// at a time (round-robin or fixed priority) and routes completions to its owner.
module dram_port_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dram_port_arbiter_if.slave   bus,
    output logic                 busy,
    output logic                 owner
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic              busy_r;
    logic              owner_r;
    logic              last_owner_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              rd_r;
    logic              wr_r;

    logic              c0_want_s;
    logic              c1_want_s;
    logic              grant_s;
    logic              grant_id_s;
    logic              grant_rd_s;
    logic              grant_wr_s;
    logic              done_s;
    logic [ADDR_W-1:0] grant_addr_s;
    logic [DATA_W-1:0] grant_data_s;

    // Next-state decode, grant selection and completion detection
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        grant_id_s   = 1'b0;
        done_s       = 1'b0;
        c0_want_s    = bus.c0_req_read | bus.c0_req_write;
        c1_want_s    = bus.c1_req_read | bus.c1_req_write;
        case (state_r)
            ST_IDLE: begin
                if (c0_want_s && c1_want_s) begin
                    grant_s      = 1'b1;
                    // last_owner_r resets to 1 so client 0 wins the first tie
                    if (FIXED_PRIO == 1'b1) begin
                        grant_id_s = 1'b0;
                    end else begin
                        grant_id_s = ~last_owner_r;
                    end
                    next_state_s = ST_BUSY;
                end else if (c0_want_s) begin
                    grant_s      = 1'b1;
                    grant_id_s   = 1'b0;
                    next_state_s = ST_BUSY;
                end else if (c1_want_s) begin
                    grant_s      = 1'b1;
                    grant_id_s   = 1'b1;
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Only a completion of the latched type ends the transaction
                if ((rd_r && bus.dram_data_valid) || (wr_r && bus.dram_write_complete)) begin
                    done_s       = 1'b1;
                    next_state_s = ST_RELEASE;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_RELEASE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Operand mux for the winning client; simultaneous read+write is a read
    always_comb begin
        if (grant_id_s) begin
            grant_addr_s = bus.c1_addr;
            grant_data_s = bus.c1_wdata;
            grant_rd_s   = bus.c1_req_read;
            grant_wr_s   = bus.c1_req_write & ~bus.c1_req_read;
        end else begin
            grant_addr_s = bus.c0_addr;
            grant_data_s = bus.c0_wdata;
            grant_rd_s   = bus.c0_req_read;
            grant_wr_s   = bus.c0_req_write & ~bus.c0_req_read;
        end
    end

    // State register, transaction latch and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            addr_r       <= {ADDR_W{1'b0}};
            data_r       <= {DATA_W{1'b0}};
            rd_r         <= 1'b0;
            wr_r         <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_BUSY);
            if (grant_s) begin
                addr_r  <= grant_addr_s;
                data_r  <= grant_data_s;
                rd_r    <= grant_rd_s;
                wr_r    <= grant_wr_s;
                owner_r <= grant_id_s;
            end else if (done_s) begin
                rd_r         <= 1'b0;
                wr_r         <= 1'b0;
                last_owner_r <= owner_r;
            end
        end
    end

    assign bus.dram_addr      = addr_r;
    assign bus.dram_data_out  = data_r;
    assign bus.dram_req_read  = rd_r;
    assign bus.dram_req_write = wr_r;

    // Completion pulses pass through in the same cycle, gated to the owner
    assign bus.c0_data_valid     = bus.dram_data_valid     & busy_r & ~owner_r & rd_r;
    assign bus.c1_data_valid     = bus.dram_data_valid     & busy_r &  owner_r & rd_r;
    assign bus.c0_write_complete = bus.dram_write_complete & busy_r & ~owner_r & wr_r;
    assign bus.c1_write_complete = bus.dram_write_complete & busy_r &  owner_r & wr_r;
    assign bus.c0_rdata          = bus.dram_data_in;
    assign bus.c1_rdata          = bus.dram_data_in;

    assign busy  = busy_r;
    assign owner = owner_r;
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: a round-robin and a fixed-priority instance share
// identical stimulus; a transaction-level model predicts each grant.
module tb_dram_port_arbiter;
    logic        clk;
    logic        rst_n;
    logic [23:0] c0_addr, c1_addr;
    logic [31:0] c0_wdata, c1_wdata;
    logic        c0_rd, c0_wr, c1_rd, c1_wr;
    logic [31:0] d_in;
    logic        d_valid, d_wcomp;
    logic        busy0, owner0, busy1, owner1;

    int n_tests = 0;
    int n_fail  = 0;
    int last_rr = 1;   // model: client that owned the last round-robin transaction

    dram_port_arbiter_if #(.ADDR_W(24), .DATA_W(32)) if0 ();
    dram_port_arbiter_if #(.ADDR_W(24), .DATA_W(32)) if1 ();

    assign if0.c0_addr = c0_addr;  assign if1.c0_addr = c0_addr;
    assign if0.c1_addr = c1_addr;  assign if1.c1_addr = c1_addr;
    assign if0.c0_wdata = c0_wdata; assign if1.c0_wdata = c0_wdata;
    assign if0.c1_wdata = c1_wdata; assign if1.c1_wdata = c1_wdata;
    assign if0.c0_req_read = c0_rd;  assign if1.c0_req_read = c0_rd;
    assign if0.c0_req_write = c0_wr; assign if1.c0_req_write = c0_wr;
    assign if0.c1_req_read = c1_rd;  assign if1.c1_req_read = c1_rd;
    assign if0.c1_req_write = c1_wr; assign if1.c1_req_write = c1_wr;
    assign if0.dram_data_in = d_in;  assign if1.dram_data_in = d_in;
    assign if0.dram_data_valid = d_valid; assign if1.dram_data_valid = d_valid;
    assign if0.dram_write_complete = d_wcomp; assign if1.dram_write_complete = d_wcomp;

    dram_port_arbiter #(.ADDR_W(24), .DATA_W(32), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .busy(busy0), .owner(owner0));
    dram_port_arbiter #(.ADDR_W(24), .DATA_W(32), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1), .owner(owner1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c0_rd = 1'b0; c0_wr = 1'b0; c1_rd = 1'b0; c1_wr = 1'b0;
        d_valid = 1'b0; d_wcomp = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        last_rr = 1;
    endtask

    task automatic test_reset();
        c0_addr = 24'h0; c1_addr = 24'h0; c0_wdata = 32'h0; c1_wdata = 32'h0; d_in = 32'h0;
        do_reset();
        n_tests++;
        if ({busy0, owner0, if0.dram_req_read, if0.dram_req_write} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {busy0, owner0, if0.dram_req_read, if0.dram_req_write});
        end
        n_tests++;
        if (if0.dram_addr !== 24'h0 || if0.dram_data_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_latch: got addr %h data %h want 0/0", if0.dram_addr, if0.dram_data_out);
        end
        n_tests++;
        if ({if0.c0_data_valid, if0.c0_write_complete, if0.c1_data_valid, if0.c1_write_complete} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 0000",
                {if0.c0_data_valid, if0.c0_write_complete, if0.c1_data_valid, if0.c1_write_complete});
        end
    endtask

    task automatic test_single_read();
        c0_addr = 24'h000123; c0_rd = 1'b1;
        tick();
        n_tests++;
        if (if0.dram_req_read !== 1'b1 || if0.dram_req_write !== 1'b0 || if0.dram_addr !== 24'h000123) begin
            n_fail++; $display("FAIL single_req: got rd %b wr %b addr %h want 1 0 000123",
                if0.dram_req_read, if0.dram_req_write, if0.dram_addr);
        end
        d_in = 32'hDEADBEEF; d_valid = 1'b1;
        #1;
        n_tests++;
        if (if0.c0_data_valid !== 1'b1 || if0.c0_rdata !== 32'hDEADBEEF || if0.c1_data_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_fwd: got c0dv %b rdata %h c1dv %b want 1 deadbeef 0",
                if0.c0_data_valid, if0.c0_rdata, if0.c1_data_valid);
        end
        tick();
        d_valid = 1'b0; c0_rd = 1'b0;
        n_tests++;
        if (if0.dram_req_read !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL single_release: got rd %b busy %b want 0 0", if0.dram_req_read, busy0);
        end
        tick();
    endtask

    task automatic test_alternation();
        int exp0;
        do_reset();
        c0_wr = 1'b1; c1_wr = 1'b1;
        for (int g = 0; g < 4; g++) begin
            c0_wdata = $urandom(); c1_wdata = $urandom();
            tick();
            exp0 = (last_rr == 0) ? 1 : 0;
            last_rr = exp0;
            n_tests++;
            if (owner0 !== exp0[0] || if0.dram_data_out !== (exp0 == 1 ? c1_wdata : c0_wdata) || if0.dram_req_write !== 1'b1) begin
                n_fail++; $display("FAIL rr_grant%0d: got owner %b data %h want %0d %h", g, owner0, if0.dram_data_out,
                    exp0, (exp0 == 1 ? c1_wdata : c0_wdata));
            end
            n_tests++;
            if (owner1 !== 1'b0 || if1.dram_data_out !== c0_wdata) begin
                n_fail++; $display("FAIL fp_grant%0d: got owner %b data %h want 0 %h", g, owner1, if1.dram_data_out, c0_wdata);
            end
            tick();
            tick();
            d_wcomp = 1'b1;
            #1;
            n_tests++;
            if (if0.c0_write_complete !== (exp0 == 0) || if0.c1_write_complete !== (exp0 == 1)) begin
                n_fail++; $display("FAIL rr_wcomp%0d: got c0 %b c1 %b for owner %0d", g,
                    if0.c0_write_complete, if0.c1_write_complete, exp0);
            end
            tick();
            d_wcomp = 1'b0;
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_addr_freeze();
        c1_addr = 24'h000010; c1_rd = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            c1_addr = 24'h000020;
            n_tests++;
            if (if0.dram_addr !== 24'h000010 || owner0 !== 1'b1) begin
                n_fail++; $display("FAIL addr_freeze%0d: got addr %h owner %b want 000010 1", k, if0.dram_addr, owner0);
            end
            tick();
        end
        d_in = 32'h0BADF00D; d_valid = 1'b1;
        #1;
        n_tests++;
        if (if0.c1_data_valid !== 1'b1 || if0.c0_data_valid !== 1'b0 || if0.c1_rdata !== 32'h0BADF00D) begin
            n_fail++; $display("FAIL freeze_fwd: got c1dv %b c0dv %b rdata %h want 1 0 0badf00d",
                if0.c1_data_valid, if0.c0_data_valid, if0.c1_rdata);
        end
        tick();
        idle_inputs();
        tick();
        last_rr = 1;
    endtask

    task automatic test_back_to_back();
        c0_addr = 24'h0000AA; c0_rd = 1'b1;
        tick();
        c1_addr = 24'h0000BB; c1_wr = 1'b1; c1_wdata = 32'h12345678;
        tick();
        d_valid = 1'b1;                // completion in cycle M
        tick();
        d_valid = 1'b0; c0_rd = 1'b0;  // cycle M+1
        n_tests++;
        if ({if0.dram_req_read, if0.dram_req_write, busy0} !== 3'b000) begin
            n_fail++; $display("FAIL b2b_m1: got %b want 000", {if0.dram_req_read, if0.dram_req_write, busy0});
        end
        tick();                        // cycle M+2
        n_tests++;
        if (if0.dram_req_write !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_m2: got wr %b busy %b want 0 0", if0.dram_req_write, busy0);
        end
        tick();                        // cycle M+3
        n_tests++;
        if (if0.dram_req_write !== 1'b1 || owner0 !== 1'b1 || if0.dram_addr !== 24'h0000BB || if0.dram_data_out !== 32'h12345678) begin
            n_fail++; $display("FAIL b2b_m3: got wr %b owner %b addr %h data %h want 1 1 0000bb 12345678",
                if0.dram_req_write, owner0, if0.dram_addr, if0.dram_data_out);
        end
        d_wcomp = 1'b1;
        tick();
        idle_inputs();
        tick();
        last_rr = 1;
    endtask

    task automatic test_reset_mid_busy();
        c1_addr = 24'h0000CC; c1_wdata = 32'hCAFE0001; c1_wr = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        c1_wr = 1'b0;
        d_wcomp = 1'b1;
        #1;
        n_tests++;
        if ({if0.c0_write_complete, if0.c1_write_complete, busy0, owner0, if0.dram_req_write} !== 5'b00000 ||
            if0.dram_addr !== 24'h0 || if0.dram_data_out !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid: got %b addr %h data %h want 00000 0 0",
                {if0.c0_write_complete, if0.c1_write_complete, busy0, owner0, if0.dram_req_write},
                if0.dram_addr, if0.dram_data_out);
        end
        tick();
        d_wcomp = 1'b0;
        n_tests++;
        if (busy0 !== 1'b0 || if0.dram_req_write !== 1'b0) begin
            n_fail++; $display("FAIL rst_late_pulse: got busy %b wr %b want 0 0", busy0, if0.dram_req_write);
        end
        c0_rd = 1'b1; c1_rd = 1'b1;
        tick();
        n_tests++;
        if (owner0 !== 1'b0 || if0.dram_req_read !== 1'b1) begin
            n_fail++; $display("FAIL rst_first_grant: got owner %b rd %b want 0 1", owner0, if0.dram_req_read);
        end
        d_valid = 1'b1;
        tick();
        idle_inputs();
        tick();
        last_rr = 0;
    endtask

    task automatic test_random();
        int pat, t0, t1, w_rr, w_fp, ty_rr, ty_fp, dly;
        logic [23:0] a_rr, a_fp;
        logic [31:0] d_rr, d_fp, rdat;
        logic [3:0]  exp_rr, exp_fp;
        for (int r = 0; r < 40; r++) begin
            pat = $urandom_range(1, 3);
            t0 = $urandom_range(1, 3); t1 = $urandom_range(1, 3);
            c0_addr = 24'($urandom()); c1_addr = 24'($urandom());
            c0_wdata = $urandom(); c1_wdata = $urandom();
            c0_rd = pat[0] & t0[0]; c0_wr = pat[0] & t0[1];
            c1_rd = pat[1] & t1[0]; c1_wr = pat[1] & t1[1];
            // transaction-level prediction: who wins and what gets latched
            if (pat == 3) begin
                w_rr = (last_rr == 0) ? 1 : 0;
                w_fp = 0;
            end else begin
                w_rr = (pat == 1) ? 0 : 1;
                w_fp = w_rr;
            end
            ty_rr = (w_rr == 0) ? t0 : t1;  ty_fp = (w_fp == 0) ? t0 : t1;
            a_rr = (w_rr == 0) ? c0_addr : c1_addr;  a_fp = (w_fp == 0) ? c0_addr : c1_addr;
            d_rr = (w_rr == 0) ? c0_wdata : c1_wdata; d_fp = (w_fp == 0) ? c0_wdata : c1_wdata;
            tick();
            c0_addr = 24'($urandom()); c1_addr = 24'($urandom());
            c0_wdata = $urandom(); c1_wdata = $urandom();
            n_tests++;
            if (owner0 !== w_rr[0] || if0.dram_addr !== a_rr || if0.dram_data_out !== d_rr ||
                if0.dram_req_read !== ty_rr[0] || if0.dram_req_write !== (ty_rr == 2)) begin
                n_fail++; $display("FAIL rand_rr%0d: got owner %b addr %h data %h rd %b wr %b want %0d %h %h type %0d",
                    r, owner0, if0.dram_addr, if0.dram_data_out, if0.dram_req_read, if0.dram_req_write, w_rr, a_rr, d_rr, ty_rr);
            end
            n_tests++;
            if (owner1 !== w_fp[0] || if1.dram_addr !== a_fp || if1.dram_data_out !== d_fp ||
                if1.dram_req_read !== ty_fp[0] || if1.dram_req_write !== (ty_fp == 2)) begin
                n_fail++; $display("FAIL rand_fp%0d: got owner %b addr %h data %h rd %b wr %b want %0d %h %h type %0d",
                    r, owner1, if1.dram_addr, if1.dram_data_out, if1.dram_req_read, if1.dram_req_write, w_fp, a_fp, d_fp, ty_fp);
            end
            dly = $urandom_range(0, 3);
            for (int k = 0; k < dly; k++) tick();
            if ((ty_rr[0] == ty_fp[0]) && ($urandom_range(0, 1) == 1)) begin
                if (ty_rr[0]) d_wcomp = 1'b1; else d_valid = 1'b1;
                tick();
                d_wcomp = 1'b0; d_valid = 1'b0;
                n_tests++;
                if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
                    n_fail++; $display("FAIL rand_wrongtype%0d: got busy %b %b want 1 1", r, busy0, busy1);
                end
            end
            rdat = $urandom();
            d_in = rdat; d_valid = 1'b1; d_wcomp = 1'b1;
            #1;
            // {c0_dv, c0_wc, c1_dv, c1_wc}: one pulse at owner, matching type
            exp_rr = ty_rr[0] ? ((w_rr == 0) ? 4'b1000 : 4'b0010) : ((w_rr == 0) ? 4'b0100 : 4'b0001);
            exp_fp = ty_fp[0] ? ((w_fp == 0) ? 4'b1000 : 4'b0010) : ((w_fp == 0) ? 4'b0100 : 4'b0001);
            n_tests++;
            if ({if0.c0_data_valid, if0.c0_write_complete, if0.c1_data_valid, if0.c1_write_complete} !== exp_rr ||
                {if1.c0_data_valid, if1.c0_write_complete, if1.c1_data_valid, if1.c1_write_complete} !== exp_fp ||
                if0.c0_rdata !== rdat || if1.c1_rdata !== rdat) begin
                n_fail++; $display("FAIL rand_fwd%0d: got rr %b fp %b want rr %b fp %b", r,
                    {if0.c0_data_valid, if0.c0_write_complete, if0.c1_data_valid, if0.c1_write_complete},
                    {if1.c0_data_valid, if1.c0_write_complete, if1.c1_data_valid, if1.c1_write_complete}, exp_rr, exp_fp);
            end
            last_rr = w_rr;
            tick();
            idle_inputs();
            n_tests++;
            if ({busy0, busy1, if0.dram_req_read, if0.dram_req_write, if1.dram_req_read, if1.dram_req_write} !== 6'b000000) begin
                n_fail++; $display("FAIL rand_release%0d: got %b want 000000", r,
                    {busy0, busy1, if0.dram_req_read, if0.dram_req_write, if1.dram_req_read, if1.dram_req_write});
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_alternation();
        test_addr_freeze();
        test_back_to_back();
        test_reset_mid_busy();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
